cvxif_issue_queue: RTL and testbench

- Coprocessor-side instruction queue on the CV-X-IF link, directly downstream of the core's cvxif request port.
- Buffers accepted offloaded instructions and collects their register operands and commit/kill decisions by instruction id.
- Releases instructions in order to the coprocessor execution unit only once they are non-speculative and all operands are present.

---
 rtl/cvxif_issue_queue_pkg.sv | 27 ++
 rtl/cvxif_iq_id_match.sv | 33 +++
 rtl/cvxif_issue_queue.sv | 182 ++++++++++++++++++
 tb/tb_cvxif_issue_queue.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvxif_issue_queue_pkg.sv
// cvxif_issue_queue_pkg: shared widths, entry layout and encodings
// for the CV-X-IF coprocessor issue queue.
package cvxif_issue_queue_pkg;

  localparam int unsigned IQ_DEPTH = 4;
  localparam int unsigned IQ_ID_W  = 4;
  localparam int unsigned IQ_XLEN  = 32;
  localparam int unsigned IQ_NR_RS = 2;
  localparam int unsigned IQ_INSTR = 32;

  localparam logic KILL   = 1'b1;
  localparam logic COMMIT = 1'b0;

  function automatic int unsigned ptr_w(int unsigned d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  typedef struct packed {
    logic [IQ_INSTR-1:0]              instr;
    logic [IQ_ID_W-1:0]               id;
    logic [IQ_NR_RS-1:0][IQ_XLEN-1:0] rs;
    logic [IQ_NR_RS-1:0]              rs_ok;
    logic                             committed;
    logic                             killed;
  } entry_t;

endpackage

// File: rtl/cvxif_iq_id_match.sv
// cvxif_iq_id_match: one-hot id lookup over queue entries plus a
// same-cycle bypass flag for the entry being enqueued.
module cvxif_iq_id_match #(
  parameter int unsigned Depth   = 4,
  parameter int unsigned IdWidth = 4
) (
  input  logic [Depth-1:0]              i_vld,
  input  logic [Depth-1:0][IdWidth-1:0] i_ids,
  input  logic                          i_q_en,
  input  logic [IdWidth-1:0]            i_qid,
  input  logic                          i_tail_en,
  input  logic [IdWidth-1:0]            i_tail_id,
  output logic [Depth-1:0]              o_hit,
  output logic                          o_byp,
  output logic                          o_any,
  output logic                          o_dup
);

  logic [Depth:0] w_all;

  always_comb begin
    o_hit = '0;
    for (int i = 0; i < Depth; i++) begin
      o_hit[i] = i_q_en & i_vld[i] & (i_ids[i] == i_qid);
    end
  end

  assign o_byp = i_q_en & i_tail_en & (i_tail_id == i_qid);
  assign w_all = {o_hit, o_byp};
  assign o_any = |w_all;
  assign o_dup = |(w_all & (w_all - 1'b1));

endmodule

// File: rtl/cvxif_issue_queue.sv
// cvxif_issue_queue: in-order offload queue gating on operands and commit.
// Define CVXIF_ISSUE_QUEUE_FLUSH_EN to add the flush_i port.
module cvxif_issue_queue
  import cvxif_issue_queue_pkg::*;
#(
  parameter int unsigned Depth       = IQ_DEPTH,
  parameter int unsigned IdWidth     = IQ_ID_W,
  parameter int unsigned XLEN        = IQ_XLEN,
  parameter int unsigned NrRgprPorts = IQ_NR_RS
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [31:0]                   issue_instr_i,
  input  logic [IdWidth-1:0]            issue_id_i,
  input  logic                          register_valid_i,
  output logic                          register_ready_o,
  input  logic [IdWidth-1:0]            register_id_i,
  input  logic [NrRgprPorts*XLEN-1:0]   register_rs_i,
  input  logic [NrRgprPorts-1:0]        register_rs_valid_i,
  input  logic                          commit_valid_i,
  input  logic [IdWidth-1:0]            commit_id_i,
  input  logic                          commit_kill_i,
  output logic                          exe_valid_o,
  input  logic                          exe_ready_i,
  output logic [31:0]                   exe_instr_o,
  output logic [IdWidth-1:0]            exe_id_o,
  output logic [NrRgprPorts*XLEN-1:0]   exe_rs_o,
  output logic [$clog2(Depth):0]        count_o
`ifdef CVXIF_ISSUE_QUEUE_FLUSH_EN
  ,
  input  logic                          flush_i
`endif
);

  localparam int unsigned PW = ptr_w(Depth);

  logic [PW:0]                   r_head;
  logic [PW:0]                   r_tail;
  logic [Depth-1:0]              r_vld;
  entry_t                        r_q [Depth];
  logic                          r_issue_rdy;

  logic                          w_flush;
  logic [PW-1:0]                 w_hidx;
  logic [PW-1:0]                 w_tidx;
  logic [Depth-1:0][IdWidth-1:0] w_ids;
  entry_t                        w_head;
  entry_t                        w_new;
  logic                          w_enq;
  logic                          w_pop;
  logic                          w_exe_ok;
  logic [PW:0]                   w_cnt_nxt;
  logic [Depth-1:0]              w_r_hit;
  logic [Depth-1:0]              w_c_hit;
  logic                          w_r_byp;
  logic                          w_c_byp;
  logic                          w_r_any;
  logic                          w_c_any;
  logic                          w_r_dup;
  logic                          w_c_dup;

`ifdef CVXIF_ISSUE_QUEUE_FLUSH_EN
  assign w_flush = flush_i;
`else
  assign w_flush = 1'b0;
`endif

  assign w_hidx = r_head[PW-1:0];
  assign w_tidx = r_tail[PW-1:0];
  assign w_head = r_q[w_hidx];

  always_comb begin
    w_ids = '0;
    for (int i = 0; i < Depth; i++) begin
      w_ids[i] = r_q[i].id;
    end
  end

  assign issue_ready_o    = r_issue_rdy & ~rst_i & ~w_flush;
  assign register_ready_o = ~rst_i;
  assign w_enq            = issue_valid_i & issue_ready_o;

  cvxif_iq_id_match #(.Depth(Depth), .IdWidth(IdWidth)) u_reg_match (
    .i_vld     (r_vld),
    .i_ids     (w_ids),
    .i_q_en    (register_valid_i & ~w_flush & ~rst_i),
    .i_qid     (register_id_i),
    .i_tail_en (w_enq),
    .i_tail_id (issue_id_i),
    .o_hit     (w_r_hit),
    .o_byp     (w_r_byp),
    .o_any     (w_r_any),
    .o_dup     (w_r_dup)
  );

  cvxif_iq_id_match #(.Depth(Depth), .IdWidth(IdWidth)) u_cmt_match (
    .i_vld     (r_vld),
    .i_ids     (w_ids),
    .i_q_en    (commit_valid_i & ~w_flush & ~rst_i),
    .i_qid     (commit_id_i),
    .i_tail_en (w_enq),
    .i_tail_id (issue_id_i),
    .o_hit     (w_c_hit),
    .o_byp     (w_c_byp),
    .o_any     (w_c_any),
    .o_dup     (w_c_dup)
  );

  // Dispatch only from stored state so updates land one cycle later
  assign w_exe_ok = r_vld[w_hidx] & w_head.committed & ~w_head.killed
                  & (&w_head.rs_ok) & ~rst_i & ~w_flush;
  assign w_pop    = r_vld[w_hidx] & ~w_flush
                  & (w_head.killed | (w_exe_ok & exe_ready_i));

  assign exe_valid_o = w_exe_ok;
  assign exe_instr_o = w_exe_ok ? w_head.instr : '0;
  assign exe_id_o    = w_exe_ok ? w_head.id : '0;
  assign exe_rs_o    = w_exe_ok ? w_head.rs : '0;

  assign count_o   = r_tail - r_head;
  assign w_cnt_nxt = count_o + (PW+1)'(w_enq) - (PW+1)'(w_pop);

  always_comb begin
    w_new       = '0;
    w_new.instr = issue_instr_i;
    w_new.id    = issue_id_i;
    for (int k = 0; k < NrRgprPorts; k++) begin
      if (w_r_byp && register_rs_valid_i[k]) begin
        w_new.rs[k]    = register_rs_i[k*XLEN +: XLEN];
        w_new.rs_ok[k] = 1'b1;
      end
    end
    if (w_c_byp) begin
      w_new.killed    = (commit_kill_i == KILL);
      w_new.committed = (commit_kill_i == COMMIT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || w_flush) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_vld       <= '0;
      r_issue_rdy <= 1'b1;
    end else begin
      r_issue_rdy <= (w_cnt_nxt != (PW+1)'(Depth));
      for (int i = 0; i < Depth; i++) begin
        if (w_r_hit[i]) begin
          for (int k = 0; k < NrRgprPorts; k++) begin
            if (register_rs_valid_i[k]) begin
              r_q[i].rs[k]    <= register_rs_i[k*XLEN +: XLEN];
              r_q[i].rs_ok[k] <= 1'b1;
            end
          end
        end
        if (w_c_hit[i]) begin
          if (commit_kill_i == KILL) r_q[i].killed <= 1'b1;
          else                       r_q[i].committed <= 1'b1;
        end
      end
      if (w_pop) begin
        r_vld[w_hidx] <= 1'b0;
        r_head        <= r_head + (PW+1)'(1);
      end
      if (w_enq) begin
        r_vld[w_tidx] <= 1'b1;
        r_q[w_tidx]   <= w_new;
        r_tail        <= r_tail + (PW+1)'(1);
      end
    end
  end

  a_reg_hit: assert property (@(posedge clk_i) disable iff (rst_i)
    (register_valid_i && !w_flush) |-> w_r_any);
  a_cmt_hit: assert property (@(posedge clk_i) disable iff (rst_i)
    (commit_valid_i && !w_flush) |-> w_c_any);
  a_no_dup: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_r_dup || w_c_dup));

endmodule

// File: tb/tb_cvxif_issue_queue.sv
// tb_cvxif_issue_queue: directed and randomized checks of the issue
// queue against a queue-based reference model.
module tb_cvxif_issue_queue;

  localparam int D  = 4;
  localparam int IW = 4;
  localparam int XL = 32;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic              issue_ready;
  logic [31:0]       issue_instr;
  logic [IW-1:0]     issue_id;
  logic              register_valid;
  logic              register_ready;
  logic [IW-1:0]     register_id;
  logic [NR*XL-1:0]  register_rs;
  logic [NR-1:0]     register_rs_valid;
  logic              commit_valid;
  logic [IW-1:0]     commit_id;
  logic              commit_kill;
  logic              exe_valid;
  logic              exe_ready;
  logic [31:0]       exe_instr;
  logic [IW-1:0]     exe_id;
  logic [NR*XL-1:0]  exe_rs;
  logic [2:0]        count;
  logic              flush = 1'b0;

  always #5 clk = ~clk;

  cvxif_issue_queue dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .issue_valid_i       (issue_valid),
    .issue_ready_o       (issue_ready),
    .issue_instr_i       (issue_instr),
    .issue_id_i          (issue_id),
    .register_valid_i    (register_valid),
    .register_ready_o    (register_ready),
    .register_id_i       (register_id),
    .register_rs_i       (register_rs),
    .register_rs_valid_i (register_rs_valid),
    .commit_valid_i      (commit_valid),
    .commit_id_i         (commit_id),
    .commit_kill_i       (commit_kill),
    .exe_valid_o         (exe_valid),
    .exe_ready_i         (exe_ready),
    .exe_instr_o         (exe_instr),
    .exe_id_o            (exe_id),
    .exe_rs_o            (exe_rs),
    .count_o             (count)
`ifdef CVXIF_ISSUE_QUEUE_FLUSH_EN
    ,
    .flush_i             (flush)
`endif
  );

  typedef struct {
    logic [31:0]      instr;
    logic [IW-1:0]    id;
    logic [NR*XL-1:0] rs;
    logic [NR-1:0]    ok;
    bit               com;
    bit               kil;
  } ment_t;

  ment_t mq[$];
  int    disp[$];
  int    checks = 0;
  int    passed = 0;

  function automatic bit m_rdy();
    return !rst && !flush && (mq.size() < D);
  endfunction

  function automatic bit m_val();
    if (rst || flush || mq.size() == 0) return 1'b0;
    return mq[0].com && !mq[0].kil && (mq[0].ok == '1);
  endfunction

  function automatic int m_idx(logic [IW-1:0] id);
    foreach (mq[i]) if (mq[i].id == id) return i;
    return -1;
  endfunction

  task automatic clr();
    issue_valid       = 1'b0;
    issue_instr       = '0;
    issue_id          = '0;
    register_valid    = 1'b0;
    register_id       = '0;
    register_rs       = '0;
    register_rs_valid = '0;
    commit_valid      = 1'b0;
    commit_id         = '0;
    commit_kill       = 1'b0;
  endtask

  task automatic tick();
    bit    enq;
    bit    pop;
    bit    shown;
    int    j;
    ment_t n;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      enq   = issue_valid && m_rdy();
      shown = m_val() && exe_ready;
      pop   = (mq.size() > 0) && (mq[0].kil || shown);
      if (register_valid) begin
        j = m_idx(register_id);
        if (j >= 0)
          for (int k = 0; k < NR; k++)
            if (register_rs_valid[k]) begin
              mq[j].rs[k*XL +: XL] = register_rs[k*XL +: XL];
              mq[j].ok[k] = 1'b1;
            end
      end
      if (commit_valid) begin
        j = m_idx(commit_id);
        if (j >= 0) begin
          if (commit_kill) mq[j].kil = 1'b1;
          else             mq[j].com = 1'b1;
        end
      end
      if (pop) begin
        if (shown) disp.push_back(int'(mq[0].id));
        void'(mq.pop_front());
      end
      if (enq) begin
        n.instr = issue_instr;
        n.id    = issue_id;
        n.rs    = '0;
        n.ok    = '0;
        n.com   = 1'b0;
        n.kil   = 1'b0;
        if (register_valid && register_id == issue_id)
          for (int k = 0; k < NR; k++)
            if (register_rs_valid[k]) begin
              n.rs[k*XL +: XL] = register_rs[k*XL +: XL];
              n.ok[k] = 1'b1;
            end
        if (commit_valid && commit_id == issue_id) begin
          if (commit_kill) n.kil = 1'b1;
          else             n.com = 1'b1;
        end
        mq.push_back(n);
      end
    end
    #1;
  endtask

  task automatic issue_full(input logic [IW-1:0] id,
                            input logic [31:0] instr,
                            input logic [NR*XL-1:0] rs);
    clr();
    issue_valid       = 1'b1;
    issue_id          = id;
    issue_instr       = instr;
    register_valid    = 1'b1;
    register_id       = id;
    register_rs       = rs;
    register_rs_valid = '1;
    commit_valid      = 1'b1;
    commit_id         = id;
    commit_kill       = 1'b0;
  endtask

  task automatic test_reset();
    clr();
    exe_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (count !== 3'd0) $display("FAIL rst_count: got %0d want 0", count);
    else passed++;
    checks++;
    if (exe_valid !== 1'b0) $display("FAIL rst_exe_valid: got %b want 0", exe_valid);
    else passed++;
    checks++;
    if (issue_ready !== 1'b0) $display("FAIL rst_issue_ready: got %b want 0", issue_ready);
    else passed++;
    checks++;
    if (register_ready !== 1'b0) $display("FAIL rst_reg_ready: got %b want 0", register_ready);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (issue_ready !== 1'b1) $display("FAIL post_rst_issue_ready: got %b want 1", issue_ready);
    else passed++;
    checks++;
    if (register_ready !== 1'b1) $display("FAIL post_rst_reg_ready: got %b want 1", register_ready);
    else passed++;
    checks++;
    if (exe_id !== '0 || exe_rs !== '0 || exe_instr !== '0)
      $display("FAIL post_rst_payload: got id %h rs %h instr %h want 0", exe_id, exe_rs, exe_instr);
    else passed++;
  endtask

  task automatic test_single();
    exe_ready = 1'b1;
    issue_full(4'd3, 32'h0000_000B, {32'h22, 32'h11});
    #1;
    checks++;
    if (issue_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", issue_ready);
    else passed++;
    tick();
    clr();
    #1;
    checks++;
    if (exe_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", exe_valid);
    else passed++;
    checks++;
    if (exe_id !== 4'd3 || exe_instr !== 32'h0000_000B)
      $display("FAIL single_id_instr: got %0d/%h want 3/0000000b", exe_id, exe_instr);
    else passed++;
    checks++;
    if (exe_rs !== {32'h22, 32'h11}) $display("FAIL single_rs: got %h want %h", exe_rs, {32'h22, 32'h11});
    else passed++;
    tick();
    checks++;
    if (count !== 3'd0 || exe_valid !== 1'b0)
      $display("FAIL single_drain: got count %0d valid %b want 0 0", count, exe_valid);
    else passed++;
  endtask

  task automatic test_fill();
    int n = 0;
    exe_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      clr();
      issue_valid = 1'b1;
      issue_id    = IW'(i);
      issue_instr = 32'h100 + 32'(i);
      tick();
    end
    clr();
    #1;
    checks++;
    if (issue_ready !== 1'b0 || count !== 3'd4)
      $display("FAIL fill_full: got ready %b count %0d want 0 4", issue_ready, count);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      clr();
      register_valid    = 1'b1;
      register_id       = IW'(i);
      register_rs       = {32'(i * 16 + 1), 32'(i * 16)};
      register_rs_valid = 2'b11;
      commit_valid      = 1'b1;
      commit_id         = IW'(i);
      tick();
    end
    clr();
    exe_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (exe_valid === 1'b1) begin
        checks++;
        if (exe_id !== IW'(n + 1) || exe_rs !== {32'((n + 1) * 16 + 1), 32'((n + 1) * 16)})
          $display("FAIL fill_order: got id %0d rs %h want id %0d", exe_id, exe_rs, n + 1);
        else passed++;
        n++;
      end
      tick();
    end
    checks++;
    if (n !== 4 || count !== 3'd0)
      $display("FAIL fill_dispatch_count: got %0d count %0d want 4 0", n, count);
    else passed++;
  endtask

  task automatic test_kill();
    int seen5 = 0;
    int seen6 = 0;
    exe_ready = 1'b0;
    clr(); issue_valid = 1'b1; issue_id = 4'd5; issue_instr = 32'h55; tick();
    clr(); issue_valid = 1'b1; issue_id = 4'd6; issue_instr = 32'h66; tick();
    clr(); commit_valid = 1'b1; commit_id = 4'd5; commit_kill = 1'b1; tick();
    clr();
    register_valid    = 1'b1;
    register_id       = 4'd6;
    register_rs       = {32'h6B, 32'h6A};
    register_rs_valid = 2'b11;
    commit_valid      = 1'b1;
    commit_id         = 4'd6;
    tick();
    clr();
    exe_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (exe_valid === 1'b1 && exe_id === 4'd5) seen5++;
      if (exe_valid === 1'b1 && exe_id === 4'd6) seen6++;
      tick();
    end
    checks++;
    if (seen5 !== 0) $display("FAIL kill_hidden: got %0d id5 dispatches want 0", seen5);
    else passed++;
    checks++;
    if (seen6 !== 1) $display("FAIL kill_next: got %0d id6 dispatches want 1", seen6);
    else passed++;
    checks++;
    if (count !== 3'd0) $display("FAIL kill_count: got %0d want 0", count);
    else passed++;
  endtask

  task automatic test_stall();
    exe_ready = 1'b0;
    clr(); issue_valid = 1'b1; issue_id = 4'd7; issue_instr = 32'h77; tick();
    clr();
    register_valid    = 1'b1;
    register_id       = 4'd7;
    register_rs       = {32'hBB, 32'hAA};
    register_rs_valid = 2'b11;
    tick();
    clr();
    #1;
    checks++;
    if (exe_valid !== 1'b0) $display("FAIL stall_uncommitted: got %b want 0", exe_valid);
    else passed++;
    commit_valid = 1'b1; commit_id = 4'd7; tick();
    clr();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (exe_valid !== 1'b1 || exe_id !== 4'd7 || exe_rs !== {32'hBB, 32'hAA})
        $display("FAIL stall_hold%0d: got v %b id %0d rs %h want 1 7 %h",
                 c, exe_valid, exe_id, exe_rs, {32'hBB, 32'hAA});
      else passed++;
      tick();
    end
    exe_ready = 1'b1;
    #1;
    checks++;
    if (exe_valid !== 1'b1) $display("FAIL stall_release: got %b want 1", exe_valid);
    else passed++;
    tick();
    exe_ready = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || exe_valid !== 1'b0)
      $display("FAIL stall_pop: got count %0d v %b want 0 0", count, exe_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    exe_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      issue_full(IW'(i), 32'h200 + 32'(i), {32'(i), 32'(i)});
      tick();
    end
    clr();
    #1;
    checks++;
    if (count !== 3'd3) $display("FAIL rmid_fill: got %0d want 3", count);
    else passed++;
    rst = 1'b1;
    exe_ready = 1'b1;
    #1;
    checks++;
    if (exe_valid !== 1'b0) $display("FAIL rmid_no_handshake: got %b want 0", exe_valid);
    else passed++;
    tick();
    rst = 1'b0;
    exe_ready = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || exe_valid !== 1'b0)
      $display("FAIL rmid_cleared: got count %0d v %b want 0 0", count, exe_valid);
    else passed++;
    issue_full(4'd2, 32'h2222, {32'h2B, 32'h2A});
    tick();
    clr();
    #1;
    checks++;
    if (exe_valid !== 1'b1 || exe_id !== 4'd2 || count !== 3'd1)
      $display("FAIL rmid_reissue: got v %b id %0d count %0d want 1 2 1", exe_valid, exe_id, count);
    else passed++;
    exe_ready = 1'b1;
    tick();
    exe_ready = 1'b0;
  endtask

  task automatic test_random();
    int           ids[$];
    bit           byp;
    logic [IW-1:0] nid;
    for (int c = 0; c < 400; c++) begin
      clr();
      exe_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        do nid = IW'($urandom_range(0, 15)); while (m_idx(nid) >= 0);
        issue_valid = 1'b1;
        issue_id    = nid;
        issue_instr = $urandom;
      end
      byp = issue_valid && m_rdy();
      if ($urandom_range(0, 1) == 1) begin
        ids.delete();
        foreach (mq[i]) ids.push_back(int'(mq[i].id));
        if (byp) ids.push_back(int'(issue_id));
        if (ids.size() > 0) begin
          register_valid    = 1'b1;
          register_id       = IW'(ids[$urandom_range(0, ids.size() - 1)]);
          register_rs       = {$urandom, $urandom};
          register_rs_valid = NR'($urandom_range(0, 3));
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        ids.delete();
        foreach (mq[i]) if (!mq[i].com && !mq[i].kil) ids.push_back(int'(mq[i].id));
        if (byp) ids.push_back(int'(issue_id));
        if (ids.size() > 0) begin
          commit_valid = 1'b1;
          commit_id    = IW'(ids[$urandom_range(0, ids.size() - 1)]);
          commit_kill  = ($urandom_range(0, 4) == 0);
        end
      end
      #1;
      checks++;
      if (exe_valid !== m_val()) $display("FAIL rnd_valid c%0d: got %b want %b", c, exe_valid, m_val());
      else passed++;
      if (m_val()) begin
        checks++;
        if (exe_id !== mq[0].id || exe_instr !== mq[0].instr || exe_rs !== mq[0].rs)
          $display("FAIL rnd_payload c%0d: got %0d/%h/%h want %0d/%h/%h", c,
                   exe_id, exe_instr, exe_rs, mq[0].id, mq[0].instr, mq[0].rs);
        else passed++;
      end else begin
        checks++;
        if (exe_id !== '0 || exe_instr !== '0 || exe_rs !== '0)
          $display("FAIL rnd_zero c%0d: got %0d/%h/%h want 0", c, exe_id, exe_instr, exe_rs);
        else passed++;
      end
      checks++;
      if (count !== 3'(mq.size())) $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, mq.size());
      else passed++;
      checks++;
      if (issue_ready !== m_rdy()) $display("FAIL rnd_ready c%0d: got %b want %b", c, issue_ready, m_rdy());
      else passed++;
      tick();
    end
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exe_ready = 1'b0;
    #1;
  endtask

`ifdef CVXIF_ISSUE_QUEUE_FLUSH_EN
  task automatic test_flush();
    exe_ready = 1'b0;
    issue_full(4'd8, 32'h88, {32'h81, 32'h80});
    tick();
    issue_full(4'd9, 32'h99, {32'h91, 32'h90});
    tick();
    clr();
    issue_valid = 1'b1;
    issue_id    = 4'd10;
    exe_ready   = 1'b1;
    flush       = 1'b1;
    #1;
    checks++;
    if (exe_valid !== 1'b0 || issue_ready !== 1'b0)
      $display("FAIL flush_gate: got v %b rdy %b want 0 0", exe_valid, issue_ready);
    else passed++;
    tick();
    flush = 1'b0;
    clr();
    exe_ready = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || exe_valid !== 1'b0)
      $display("FAIL flush_clear: got count %0d v %b want 0 0", count, exe_valid);
    else passed++;
  endtask
`endif

  initial begin
    rst       = 1'b1;
    exe_ready = 1'b0;
    clr();
    test_reset();
    test_single();
    test_fill();
    test_kill();
    test_stall();
    test_random();
    test_reset_mid();
`ifdef CVXIF_ISSUE_QUEUE_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
